io_port_ctrl: RTL

//  Responder side of the CPU output-port instructions: WO (4'h9) writes $rs to the port, RO (4'hA) reads the port into $rs.

---
 rtl/io_port_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/io_port_ctrl.sv
// Responder for the CPU port instructions WO/RO: a TX FIFO drains CPU writes to an
// external sink, and an RX FIFO buffers words from an external source for CPU reads.
module io_port_ctrl #(
  parameter int WORD     = 8,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wo_en,
  input  logic [WORD-1:0]           wo_data,
  input  logic                      ro_en,
  output logic [WORD-1:0]           ro_data,
  output logic                      stall,
  output logic [WORD-1:0]           out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic [WORD-1:0]           in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [$clog2(RX_DEPTH):0] rx_count
);

  localparam int TXP = $clog2(TX_DEPTH);
  localparam int RXP = $clog2(RX_DEPTH);
  localparam logic [TXP:0] TX_FULL_CNT = (TXP + 1)'(TX_DEPTH);
  localparam logic [RXP:0] RX_FULL_CNT = (RXP + 1)'(RX_DEPTH);

  // Handshakes: a word moves on a cycle where valid & ready are both high at the
  // rising edge; valid never drops and data never changes until that happens.

  logic [WORD-1:0] tx_mem [TX_DEPTH];
  logic [TXP-1:0]  tx_wr;
  logic [TXP-1:0]  tx_rd;
  logic            tx_full;
  logic            tx_empty;
  logic            tx_push;
  logic            tx_pop;

  logic [WORD-1:0] rx_mem [RX_DEPTH];
  logic [RXP-1:0]  rx_wr;
  logic [RXP-1:0]  rx_rd;
  logic            rx_full;
  logic            rx_empty;
  logic            rx_push;
  logic            rx_pop;

  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_empty = (rx_count == '0);

  // Full/empty come only from registered counts, so a same-cycle drain or fill
  // never frees space combinationally and stall has no path from the handshakes.
  assign tx_push   = wo_en & ~tx_full;
  assign out_valid = ~tx_empty;
  assign tx_pop    = out_valid & out_ready;
  assign out_data  = tx_empty ? '0 : tx_mem[tx_rd];

  assign in_ready  = ~rx_full;
  assign rx_push   = in_valid & in_ready;
  assign rx_pop    = ro_en & ~rx_empty;
  assign ro_data   = rx_empty ? '0 : rx_mem[rx_rd];

  assign stall = (wo_en & tx_full) | (ro_en & rx_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr] <= wo_data;
        tx_wr         <= tx_wr + TXP'(1);
      end
      if (tx_pop) tx_rd <= tx_rd + TXP'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + (TXP + 1)'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - (TXP + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr] <= in_data;
        rx_wr         <= rx_wr + RXP'(1);
      end
      if (rx_pop) rx_rd <= rx_rd + RXP'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + (RXP + 1)'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - (RXP + 1)'(1);
    end
  end

endmodule
